// File: rtl/lighthouse_sample_fifo.sv
// Sample FIFO between lighthouse_sensor and the HPS Avalon slave: push on ready rising edge, pop on DATA read.
// Optional build macro LH_FIFO_TIMESTAMP_EN adds a per-sample cycle timestamp readable at address 4.
module lighthouse_sample_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sample_ready,
    input  logic [31:0] sample_data,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        waitrequest
);

    localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [31:0] EMPTY_WORD = 32'hDEAD_BEEF;
    localparam logic [31:0] ID_WORD    = 32'h4C48_0001;

    logic                  ready_q;
    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic [31:0]           drops;
    logic                  overflow;
    logic [31:0]           status;

    logic push, pop, empty, full, store, drop, ctrl_wr, flush, clear;
    logic unused_writedata;

    assign push    = sample_ready & ~ready_q;
    assign empty   = (count == '0);
    assign full    = (count == (DEPTH_LOG2 + 1)'(DEPTH));
    assign pop     = read & (address == 3'd1) & ~empty;
    assign ctrl_wr = write & (address == 3'd2);
    assign flush   = ctrl_wr & writedata[0];
    assign clear   = ctrl_wr & writedata[1];
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign store   = push & (~full | pop) & ~flush;
    assign drop    = push & full & ~pop & ~flush;

    assign waitrequest      = 1'b0;
    assign unused_writedata = ^writedata[31:2];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ready_q  <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drops    <= '0;
            overflow <= 1'b0;
        end else begin
            ready_q <= sample_ready;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (store) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
                if (pop)   rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
                case ({store, pop})
                    2'b10:   count <= count + (DEPTH_LOG2 + 1)'(1);
                    2'b01:   count <= count - (DEPTH_LOG2 + 1)'(1);
                    default: count <= count;
                endcase
            end
            if (clear) begin
                drops    <= '0;
                overflow <= 1'b0;
            end else if (drop) begin
                overflow <= 1'b1;
                if (drops != '1) drops <= drops + 32'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (store) mem[wr_ptr] <= sample_data;
    end

`ifdef LH_FIFO_TIMESTAMP_EN
    logic [31:0] cycle_count;
    logic [31:0] ts_mem [DEPTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) cycle_count <= '0;
        else       cycle_count <= cycle_count + 32'd1;
    end

    always_ff @(posedge clock) begin
        if (store) ts_mem[wr_ptr] <= cycle_count;
    end
`endif

    always_comb begin
        status               = '0;
        status[31]           = overflow;
        status[30]           = empty;
        status[29]           = full;
        status[DEPTH_LOG2:0] = count;
        readdata             = EMPTY_WORD;
        case (address)
            3'd0: readdata = status;
            3'd1: if (!empty) readdata = mem[rd_ptr];
            3'd2: readdata = drops;
            3'd3: readdata = ID_WORD;
`ifdef LH_FIFO_TIMESTAMP_EN
            3'd4: if (!empty) readdata = ts_mem[rd_ptr];
`endif
            default: readdata = EMPTY_WORD;
        endcase
    end

endmodule

// File: doc/lighthouse_sample_fifo.md
# lighthouse_sample_fifo

Buffers decoded lighthouse sweep samples between the `lighthouse_sensor` decoder and the HPS Avalon bus, so software can drain samples in bursts without losing sweeps. Each rising edge of the decoder's `ready` pushes that cycle's `combined_data` word into a circular FIFO. The Avalon slave then exposes status, pop-on-read data, drop statistics and control. It sits directly downstream of `lighthouse_sensor` and replaces the direct register tap used in bring-up.

## Interface
Parameters:
- `DEPTH_LOG2`, 4: FIFO depth is 2^DEPTH_LOG2 entries (16); legal range 2–8.

Ports (clock and reset first):
- `clock`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `sample_ready`  in  1  level `ready` from `lighthouse_sensor`; a push happens on its 0→1 transition.
- `sample_data`  in  32  `combined_data` from the decoder; sampled in the push cycle.
- `address`  in  3  Avalon word address.
- `read`  in  1  Avalon read strobe.
- `write`  in  1  Avalon write strobe.
- `writedata`  in  32  Avalon write data.
- `readdata`  out  32  Avalon read data; combinational from `address` and FIFO state.
- `waitrequest`  out  1  tied to 0; every access completes in one cycle.

## Operation
Edge detection:
- `ready_q` is `sample_ready` registered one cycle; reset value 0.
- `push = sample_ready & ~ready_q`.

FIFO storage:
- 2^DEPTH_LOG2 × 32 register array.
- `wr_ptr` and `rd_ptr` are DEPTH_LOG2 bits and wrap modulo depth.
- `count` is DEPTH_LOG2+1 bits, range 0..depth.

Pop:
- `pop = read & (address==1) & (count!=0)`.
- Exactly one pop per asserted read cycle.

Register map, read side:
- 0 STATUS: [31] overflow sticky, [30] empty, [29] full, [DEPTH_LOG2:0] count, other bits 0.
- 1 DATA: head entry, and the read pops it. Returns 32'hDEAD_BEEF when empty; no pointer change.
- 2 DROPS: count of pushes rejected because the FIFO was full. Saturates at 32'hFFFF_FFFF.
- 3 ID: 32'h4C48_0001.
- 4 TIMESTAMP: see Configuration.
- Any other address: 32'hDEAD_BEEF.

Register map, write side (address 2, CONTROL):
- bit0 flush: pointers and count go to 0. Data array is not cleared.
- bit1 clear overflow sticky and DROPS.
- Writes to any other address are ignored.

Boundary rules:
- Full with push and no pop: push dropped, overflow set, DROPS += 1.
- Full with push and pop in the same cycle: both occur, count unchanged, no drop.
- Empty with push and DATA read in the same cycle: read returns DEAD_BEEF, no pop; push is stored and count becomes 1.
- Flush in the same cycle as push and/or pop: flush wins, count becomes 0, push discarded without a drop count, popped value is still returned on `readdata`.
- Clear in the same cycle as a drop: clear wins; overflow=0 and DROPS=0.
- `reset` mid-operation: all state clears immediately.

## Timing
- Reset values: `readdata` reflects the reset state (STATUS = 32'h4000_0000), `waitrequest` = 0, `ready_q` = 0, pointers/count/DROPS/overflow = 0.
- Push latency: the `sample_ready` rising edge at clock edge N shows count+1 in STATUS and data at head after edge N+1.
- Read latency: zero-wait; `readdata` is valid in the same cycle as `read`. Pointer and count update at the closing clock edge.
- Back-to-back DATA reads drain one entry per cycle.

## Configuration
- `LH_FIFO_TIMESTAMP_EN` defined:
  - A free-running 32-bit cycle counter (reset 0, wraps) is captured alongside each pushed sample into a parallel array.
  - Address 4 returns the head entry's timestamp without popping; software reads 4 then 1.
  - Empty returns 32'hDEAD_BEEF.
  - Flush and pointers apply identically to both arrays.
- `LH_FIFO_TIMESTAMP_EN` undefined: no counter or timestamp array; address 4 returns 32'hDEAD_BEEF.

## Test plan
- Reset, then read addresses 0/1/2/3/5 → 32'h4000_0000, 32'hDEAD_BEEF, 0, 32'h4C48_0001, 32'hDEAD_BEEF; `waitrequest` is 0 throughout.
- Three `sample_ready` pulses with data 0xA1, 0xA2, 0xA3 (ready held high 5 cycles each) → STATUS count=3. DATA reads return A1, A2, A3, then DEAD_BEEF with empty=1. A held-high ready never double-pushes.
- With DEPTH_LOG2=4, 18 pulses and no reads → full=1, count=16, overflow=1, DROPS=2. Reads return the first 16 values in order. Then write CONTROL=2 → STATUS overflow=0, DROPS=0.
- Full FIFO with a push edge coinciding with a DATA read → oldest value returned, count stays 16, DROPS unchanged. Empty FIFO with a push coinciding with a DATA read → DEAD_BEEF returned, count=1.
- Five entries, then CONTROL=1 written in the same cycle as a push edge → count=0, DROPS=0. Assert `reset` while count=7 → STATUS returns to 32'h4000_0000 immediately.
- With `LH_FIFO_TIMESTAMP_EN`: pushes 10 cycles apart → address-4 reads differ by 10, and the timestamp follows the head after each pop. Without the macro, address 4 returns DEAD_BEEF.
